load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 Parameter TIMEOUT, default 16: maximum number of REQ-state cycles spent waiting for mem_ack before a timeout fault.
- REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
- REQ-003 rst  in  1  reset; one clock, reset is synchronous and active-high.
- REQ-004 req_valid  in  1  core has a load/store in its current instruction; held until done.
- REQ-005 req_we  in  1  1 = store, 0 = load (core memrw).
- REQ-006 req_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-007 req_addr  in  32  byte address (core ALU_result).
- REQ-008 req_wdata  in  32  store data (rs2).
- REQ-009 stall  out  1  hold PC and register write.
- REQ-010 done  out  1  one-cycle completion pulse.
- REQ-011 rdata  out  32  extended load data, valid while done=1.
- REQ-012 fault  out  1  access failed; valid while done=1.
- REQ-013 fault_code  out  2  01 misaligned, 10 timeout, 11 illegal funct3, 00 none.
- REQ-014 mem_req, mem_we  out  1 each  bus request, bus write.
- REQ-015 mem_addr  out  32  word address: {req_addr[31:2], 2'b00}.
- REQ-016 mem_wstrb  out  4 / mem_wdata  out  32  byte lane enables, lane-replicated store data.
- REQ-017 mem_ack  in  1 / mem_rdata  in  32  bus completion, read word.

Function
- REQ-018 FSM states: IDLE, REQ, DONE.
- REQ-019 In IDLE with req_valid=1 and a legal, aligned access, the unit SHALL latch addr, we, funct3, strobes and lane data, then enter REQ.
- REQ-020 In IDLE with req_valid=1 and an illegal funct3 (any load funct3 of 011/110/111, or any store funct3 other than 000/001/010), the unit SHALL enter DONE with fault_code=11 and SHALL NOT assert mem_req.
- REQ-021 In IDLE with req_valid=1 and a misaligned access (H with addr[0]=1; W with addr[1:0]!=0), the unit SHALL enter DONE with fault_code=01 and SHALL NOT assert mem_req.
- REQ-022 Illegal funct3 SHALL take priority over misalignment.
- REQ-023 mem_req SHALL equal 1 exactly while in REQ; mem_addr, mem_we, mem_wstrb and mem_wdata SHALL stay stable throughout REQ.
- REQ-024 In REQ, mem_ack=1 SHALL capture mem_rdata and move the FSM to DONE.
- REQ-025 A wait counter SHALL clear on REQ entry and increment on each REQ cycle without ack.
- REQ-026 When the wait counter reaches TIMEOUT-1 with no ack, the FSM SHALL move to DONE with fault_code=10 and rdata=0.
- REQ-027 In DONE, done=1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
- REQ-028 stall = req_valid & ~done.
- REQ-029 Minimum latency is 3 cycles (IDLE accept, REQ with ack, DONE); a fault detected in IDLE completes in 2 cycles.
- REQ-030 Load extension: B/BU select byte addr[1:0]; H/HU select half addr[1]; B/H sign-extend; BU/HU zero-extend; W passes the word through.
- REQ-031 Store strobes: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111.
- REQ-032 Store data lanes: SB replicates byte [7:0] into all 4 lanes; SH replicates half [15:0] into both halves.
- REQ-033 Stores SHALL report rdata=0 in DONE.
- REQ-034 mem_ack outside REQ SHALL be ignored.
- REQ-035 With req_valid=0 in IDLE, the unit SHALL stay in IDLE with all outputs 0.

Reset
- REQ-036 rst=1 SHALL force IDLE, clear the wait counter, and drive stall, done, fault, fault_code, rdata, mem_req, mem_we, mem_wstrb, mem_wdata and mem_addr to 0 on the next edge.
- REQ-037 rst asserted during REQ SHALL drop mem_req on the next edge; a late ack SHALL have no effect.

Verification
- REQ-038 LB addr=0x103, mem_rdata=0x80FF_1234, ack in first REQ cycle -> done at cycle 2, rdata=0xFFFF_FF80, mem_addr=0x100, stall high in cycles 0-1.
- REQ-039 LHU addr=0x102, mem_rdata=0x8001_0000 -> rdata=0x0000_8001, fault=0.
- REQ-040 SB addr=0x201, wdata=0x0000_00AB -> mem_wstrb=0010, mem_wdata=0xABAB_ABAB, mem_we=1, rdata=0.
- REQ-041 LW addr=0x102 -> done after 2 cycles, fault=1, fault_code=01, mem_req never asserted; funct3=011 load -> fault_code=11.
- REQ-042 LW with ack held low, TIMEOUT=16 -> 16 REQ cycles, then done with fault_code=10, rdata=0, mem_req=0 afterward.
- REQ-043 rst pulsed on the 3rd REQ cycle, then ack=1 -> mem_req=0, done never asserted, FSM in IDLE.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one outstanding word request, completed by mem_ack.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core byte/half/word access into one word bus transaction,
// with misalignment, illegal-size and bus-timeout faults reported on a one-cycle done pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     stall,
  output logic                     done,
  output logic [31:0]              rdata,
  output logic                     fault,
  output logic [1:0]               fault_code,
  load_store_unit_if.master        mem
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] FcNone       = 2'b00;
  localparam logic [1:0] FcMisaligned = 2'b01;
  localparam logic [1:0] FcTimeout    = 2'b10;
  localparam logic [1:0] FcIllegal    = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e state_q, state_d;

  logic [29:0]     addr_q, addr_d;
  logic [1:0]      off_q, off_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      code_q, code_d;

  logic        illegal, misaligned;
  logic [3:0]  strb;
  logic [31:0] lanes;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Request decode from the live core inputs; only consumed in StIdle.
  always_comb begin
    illegal = req_we ? (req_funct3 > 3'b010)
                     : (req_funct3 inside {3'b011, 3'b110, 3'b111});
    misaligned = 1'b0;
    strb       = 4'b1111;
    lanes      = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << req_addr[1:0];
        lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        strb       = req_addr[1] ? 4'b1100 : 4'b0011;
        lanes      = {2{req_wdata[15:0]}};
      end
      default: begin
        misaligned = |req_addr[1:0];
      end
    endcase
  end

  always_comb begin
    lane_byte = mem.mem_rdata[{off_q, 3'b000} +: 8];
    lane_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'b0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'b0, lane_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = (illegal || misaligned) ? StDone : StReq;
        end
      end
      StReq: begin
        if (mem.mem_ack || (cnt_q == CntLast)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      code_q   <= FcNone;
    end else begin
      addr_q   <= addr_d;
      off_q    <= off_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    off_d    = off_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    code_d   = code_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid) begin
          addr_d   = req_addr[31:2];
          off_d    = req_addr[1:0];
          we_d     = req_we;
          funct3_d = req_funct3;
          wstrb_d  = req_we ? strb : 4'b0000;
          wdata_d  = req_we ? lanes : 32'b0;
          rdata_d  = '0;
          code_d   = illegal ? FcIllegal : (misaligned ? FcMisaligned : FcNone);
        end
      end
      StReq: begin
        if (mem.mem_ack) begin
          rdata_d = we_q ? 32'b0 : load_ext;
          code_d  = FcNone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            rdata_d = '0;
            code_d  = FcTimeout;
          end
        end
      end
      default: ;
    endcase
  end

  // Bus fields are forced to zero outside StReq so an idle unit presents a quiet bus.
  always_comb begin
    done           = (state_q == StDone);
    stall          = req_valid & ~done;
    rdata          = done ? rdata_q : 32'b0;
    fault_code     = done ? code_q : FcNone;
    fault          = done & (code_q != FcNone);
    mem.mem_req    = (state_q == StReq);
    mem.mem_we     = mem.mem_req & we_q;
    mem.mem_addr   = mem.mem_req ? {addr_q, 2'b00} : 32'b0;
    mem.mem_wstrb  = mem.mem_req ? wstrb_q : 4'b0000;
    mem.mem_wdata  = mem.mem_req ? wdata_q : 32'b0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized accesses
// against an arithmetic reference model of the access rules.
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .fault      (fault),
    .fault_code (fault_code),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctrl"}, {22'b0, stall, done, fault, fault_code, mem_bus.mem_req,
                         mem_bus.mem_we, mem_bus.mem_wstrb}, 32'b0);
    chk({tag, "_rdata"}, rdata, 32'b0);
    chk({tag, "_maddr"}, mem_bus.mem_addr, 32'b0);
    chk({tag, "_mwdata"}, mem_bus.mem_wdata, 32'b0);
  endtask

  // One access; delay = number of REQ cycles before ack (>= TIMEOUT means never ack).
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int delay);
    int unsigned sz, off, nreq, nseen, cyc;
    bit          illegal, got_done;
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata, exp_strb, exp_wdata, v;

    sz      = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    off     = addr % 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (illegal)              exp_code = 2'b11;
    else if (addr % sz != 0)  exp_code = 2'b01;
    else if (delay >= int'(TIMEOUT)) exp_code = 2'b10;
    else                      exp_code = 2'b00;
    nreq = (exp_code == 2'b11 || exp_code == 2'b01) ? 0
         : ((delay >= int'(TIMEOUT)) ? TIMEOUT : delay + 1);

    exp_strb  = we ? (((32'd1 << sz) - 1) << off) : 32'd0;
    exp_wdata = !we ? 32'd0 : (sz == 1) ? (wd % 256) * 32'h0101_0101
              : (sz == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
    exp_rdata = 32'd0;
    if (!we && exp_code == 2'b00) begin
      v = rd >> (8 * off);
      if (sz == 1) begin
        v = v % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2) begin
        v = v % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      exp_rdata = v;
    end

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    nseen      = 0;
    cyc        = 0;
    got_done   = 1'b0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        chk("done_stall", {31'b0, stall}, 32'd0);
        chk("done_cycle", cyc, 1 + nreq);
        chk("req_cycles", nseen, nreq);
        chk("rdata", rdata, exp_rdata);
        chk("fault", {31'b0, fault}, {31'b0, exp_code != 2'b00});
        chk("fault_code", {30'b0, fault_code}, {30'b0, exp_code});
        mem_bus.mem_ack   = 1'($urandom % 2);
        mem_bus.mem_rdata = $urandom;
      end else begin
        chk("stall", {31'b0, stall}, 32'd1);
        if (mem_bus.mem_req) begin
          chk("mem_addr", mem_bus.mem_addr, addr - off);
          chk("mem_we", {31'b0, mem_bus.mem_we}, {31'b0, we});
          chk("mem_wstrb", {28'b0, mem_bus.mem_wstrb}, exp_strb);
          chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
          mem_bus.mem_ack   = (int'(nseen) == delay);
          mem_bus.mem_rdata = (int'(nseen) == delay) ? rd : $urandom;
          nseen++;
        end else begin
          // Stray acks outside a bus request must be ignored.
          mem_bus.mem_ack   = 1'($urandom % 2);
          mem_bus.mem_rdata = $urandom;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!got_done) chk("done_seen", 32'd0, 32'd1);
    req_valid       = 1'b0;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk_idle("after_done");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned nseen, r;
    int          delay;

    rst               = 1'b1;
    req_valid         = 1'b0;
    req_we            = 1'b0;
    req_funct3        = 3'b000;
    req_addr          = 32'b0;
    req_wdata         = 32'b0;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    mem_bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("idle_no_req");
    @(posedge clk);
    #1;

    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);  // LB sign-extend
    run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 0);  // LHU upper half
    run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 1);  // SB lane 1
    run_txn(1'b1, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 32'h0, 2);  // SH upper half
    run_txn(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 0);  // SW
    run_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0);          // LW misaligned
    run_txn(1'b0, 3'b001, 32'h0000_0105, 32'h0, 32'h0, 0);          // LH misaligned
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);          // illegal load
    run_txn(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0);          // illegal store
    run_txn(1'b1, 3'b110, 32'h0000_0101, 32'h0, 32'h0, 0);          // illegal beats misaligned
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 99);         // timeout
    run_txn(1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'hF00F_0000, TIMEOUT - 1); // ack on last cycle

    // Reset during the third REQ cycle, then a late ack must be ignored.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0100;
    nseen      = 0;
    for (int c = 0; c < 10 && nseen < 3; c++) begin
      @(negedge clk);
      if (mem_bus.mem_req) nseen++;
      if (nseen == 3) begin
        rst       = 1'b1;
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("rst_req_cycles", nseen, 3);
    rst               = 1'b0;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1111_2222;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle("after_rst");
      @(posedge clk);
      #1;
    end
    mem_bus.mem_ack = 1'b0;

    for (int i = 0; i < 150; i++) begin
      r     = $urandom_range(0, 9);
      delay = (r == 9) ? 99 : int'(r % 4);
      run_txn(1'($urandom % 2), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, delay);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
